// File: rtl/ddr2_port_arbiter_if.sv
// ddr2_port_arbiter_if: client handshakes and DDR2 command-port signals shared by the arbiter
interface ddr2_port_arbiter_if;
  logic        calib_done;
  logic        wr_req;
  logic [29:0] wr_addr;
  logic        wr_gnt;
  logic        wr_done;
  logic        rd_req;
  logic [29:0] rd_addr;
  logic        rd_gnt;
  logic        rd_done;
  logic        p0_cmd_full;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [29:0] p0_cmd_byte_addr;
  logic [5:0]  p0_cmd_bl;
  logic        timeout_err;
  modport master (
    input  calib_done, wr_req, wr_addr, wr_done, rd_req, rd_addr, rd_done, p0_cmd_full,
    output wr_gnt, rd_gnt, p0_cmd_en, p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl, timeout_err
  );
  modport slave (
    output calib_done, wr_req, wr_addr, wr_done, rd_req, rd_addr, rd_done, p0_cmd_full,
    input  wr_gnt, rd_gnt, p0_cmd_en, p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl, timeout_err
  );
endinterface

// File: rtl/ddr2_port_arbiter.sv
// ddr2_port_arbiter: round-robin sharing of one DDR2 command port between a write and a read client
module ddr2_port_arbiter #(
  parameter int BURST_LEN = 32,
  parameter int TIMEOUT   = 4095
) (
  input logic clk,
  input logic reset,
  ddr2_port_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_GNT, WR_CMD, RD_CMD, RD_GNT} state_t;
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);
  state_t      r_state, w_next;
  logic [29:0] r_addr;
  logic [2:0]  r_instr;
  logic        r_wr_turn;
  logic [11:0] r_wdog;
  logic        r_timeout_err;
  logic        w_pick_wr, w_pick_rd, w_in_gnt, w_done, w_timeout;
  assign w_pick_wr = bus.calib_done && bus.wr_req && (!bus.rd_req || r_wr_turn);
  assign w_pick_rd = bus.calib_done && bus.rd_req && !w_pick_wr;
  assign w_in_gnt  = r_state == WR_GNT || r_state == RD_GNT;
  assign w_done    = r_state == WR_GNT ? bus.wr_done : r_state == RD_GNT ? bus.rd_done : 1'b0;
  assign w_timeout = w_in_gnt && !w_done && r_wdog == WD_LAST;
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // next state: grant in IDLE, wait for done or watchdog in grant states, wait for FIFO room in command states
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pick_wr ? WR_GNT : w_pick_rd ? RD_CMD : IDLE;
      WR_GNT:  w_next = w_done ? WR_CMD : w_timeout ? IDLE : WR_GNT;
      WR_CMD:  w_next = bus.p0_cmd_full ? WR_CMD : IDLE;
      RD_CMD:  w_next = bus.p0_cmd_full ? RD_CMD : RD_GNT;
      RD_GNT:  w_next = (w_done || w_timeout) ? IDLE : RD_GNT;
      default: w_next = IDLE;
    endcase
  end
  // command address/instr latched at grant, round-robin pointer, grant watchdog and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr        <= '0;
      r_instr       <= '0;
      r_wr_turn     <= 1'b1;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE && (w_pick_wr || w_pick_rd)) begin
        r_addr    <= w_pick_wr ? bus.wr_addr : bus.rd_addr;
        r_instr   <= {2'b00, !w_pick_wr};
        r_wr_turn <= !w_pick_wr;
      end
      r_wdog        <= w_in_gnt ? r_wdog + 12'd1 : '0;
      r_timeout_err <= r_timeout_err || w_timeout;
    end
  end
  // grants and strobe decoded from state; reset silences them so an aborted sequence never strobes
  always_comb begin
    bus.wr_gnt    = !reset && r_state == WR_GNT;
    bus.rd_gnt    = !reset && (r_state == RD_CMD || r_state == RD_GNT);
    bus.p0_cmd_en = !reset && !bus.p0_cmd_full && (r_state == WR_CMD || r_state == RD_CMD);
  end
  assign bus.p0_cmd_instr     = r_instr;
  assign bus.p0_cmd_byte_addr = r_addr;
  assign bus.p0_cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.timeout_err      = r_timeout_err;
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// tb_ddr2_port_arbiter: scoreboard bench for the DDR2 port arbiter
module tb_ddr2_port_arbiter;
  typedef struct {
    logic [2:0]  instr;
    logic [29:0] addr;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0, n_bad = 0, cmd_cnt = 0, c0;
  bit   both_hi, any_gnt;
  exp_t q[$];
  ddr2_port_arbiter_if bus();
  ddr2_port_arbiter #(.BURST_LEN(32), .TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_done = 0; bus.rd_done = 0;
    bus.p0_cmd_full = 0; bus.calib_done = 1;
    tick();
    tick();
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 0);
    chk("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    reset = 1'b0;
  endtask
  task automatic wait_gnt(input bit rd);
    int n = 0;
    while (!(rd ? bus.rd_gnt : bus.wr_gnt) && n < 30) begin
      tick();
      n++;
    end
    chk(rd ? "rd_gnt_wait" : "wr_gnt_wait", 32'(rd ? bus.rd_gnt : bus.wr_gnt), 1);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, q.size(), 0);
  endtask
  // command monitor: every strobe must match the oldest expected command
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_gnt && bus.rd_gnt) both_hi = 1;
    if (bus.wr_gnt || bus.rd_gnt) any_gnt = 1;
    if (bus.p0_cmd_en) begin
      cmd_cnt++;
      if (q.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("cmd_instr", 32'(bus.p0_cmd_instr), 32'(e.instr));
        chk("cmd_addr", 32'(bus.p0_cmd_byte_addr), 32'(e.addr));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    int n;
    bit lost;
    bus.wr_addr = 0; bus.rd_addr = 0;
    do_reset();
    reset = 1'b1;
    chk("rst_cmd_en", 32'(bus.p0_cmd_en), 0);
    chk("rst_instr", 32'(bus.p0_cmd_instr), 0);
    chk("rst_addr", 32'(bus.p0_cmd_byte_addr), 0);
    chk("cmd_bl", 32'(bus.p0_cmd_bl), 31);
    reset = 1'b0;
    // single write burst
    c0 = cmd_cnt;
    bus.wr_addr = 30'h80; bus.wr_req = 1;
    q.push_back('{3'b000, 30'h80});
    wait_gnt(0);
    bus.wr_req = 0; bus.wr_addr = 30'h3FFFFFFF;
    chk("w_addr_latch", 32'(bus.p0_cmd_byte_addr), 32'h80);
    chk("w_rd_gnt_low", 32'(bus.rd_gnt), 0);
    repeat (9) tick();
    bus.wr_done = 1;
    tick();
    bus.wr_done = 0;
    chk("w_gnt_drop", 32'(bus.wr_gnt), 0);
    drain("w_drain");
    repeat (3) tick();
    chk("w_cmd_cnt", cmd_cnt - c0, 1);
    chk("w_addr_hold", 32'(bus.p0_cmd_byte_addr), 32'h80);
    // both clients contending: W,R,W,R
    do_reset();
    c0 = cmd_cnt; both_hi = 0;
    bus.wr_addr = 30'h100; bus.rd_addr = 30'h200;
    q.push_back('{3'b000, 30'h100}); q.push_back('{3'b001, 30'h200});
    q.push_back('{3'b000, 30'h100}); q.push_back('{3'b001, 30'h200});
    bus.wr_req = 1; bus.rd_req = 1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      bus.wr_done = bus.wr_gnt && !bus.wr_done;
      bus.rd_done = bus.rd_gnt && !bus.rd_done;
      tick();
      n++;
    end
    bus.wr_req = 0; bus.rd_req = 0;
    n = 0;
    while ((bus.wr_gnt || bus.rd_gnt) && n < 20) begin
      bus.wr_done = bus.wr_gnt && !bus.wr_done;
      bus.rd_done = bus.rd_gnt && !bus.rd_done;
      tick();
      n++;
    end
    bus.wr_done = 0; bus.rd_done = 0;
    tick();
    chk("rr_drain", q.size(), 0);
    chk("rr_both_high", 32'(both_hi), 0);
    chk("rr_cmd_cnt", cmd_cnt - c0, 4);
    // read held off by a full command FIFO
    do_reset();
    c0 = cmd_cnt;
    bus.p0_cmd_full = 1; bus.rd_addr = 30'h2A4; bus.rd_req = 1;
    q.push_back('{3'b001, 30'h2A4});
    wait_gnt(1);
    bus.rd_req = 0;
    lost = 0;
    repeat (20) begin
      tick();
      if (!bus.rd_gnt) lost = 1;
    end
    chk("r_full_gnt_hold", 32'(lost), 0);
    chk("r_full_no_cmd", cmd_cnt - c0, 0);
    bus.p0_cmd_full = 0;
    tick();
    chk("r_cmd_issued", cmd_cnt - c0, 1);
    chk("r_gnt_after_cmd", 32'(bus.rd_gnt), 1);
    repeat (5) tick();
    chk("r_gnt_wait_done", 32'(bus.rd_gnt), 1);
    bus.rd_done = 1;
    tick();
    bus.rd_done = 0;
    chk("r_gnt_drop", 32'(bus.rd_gnt), 0);
    chk("r_instr_hold", 32'(bus.p0_cmd_instr), 1);
    chk("r_addr_hold", 32'(bus.p0_cmd_byte_addr), 32'h2A4);
    // watchdog expiry with no done
    do_reset();
    c0 = cmd_cnt;
    bus.wr_req = 1;
    wait_gnt(0);
    bus.wr_req = 0;
    n = 1;
    while (n < 40) begin
      tick();
      if (!bus.wr_gnt) break;
      n++;
    end
    chk("to_gnt_len", n, 15);
    chk("to_err_set", 32'(bus.timeout_err), 1);
    bus.wr_done = 1;
    tick();
    bus.wr_done = 0;
    repeat (5) tick();
    chk("to_err_held", 32'(bus.timeout_err), 1);
    chk("to_no_cmd", cmd_cnt - c0, 0);
    chk("to_stale_done", 32'(bus.wr_gnt), 0);
    // calibration gating, then calib falling mid-sequence
    do_reset();
    bus.calib_done = 0; any_gnt = 0;
    bus.wr_addr = 30'h40; bus.rd_addr = 30'h50;
    bus.wr_req = 1; bus.rd_req = 1;
    repeat (10) tick();
    chk("cal_no_gnt", 32'(any_gnt), 0);
    q.push_back('{3'b000, 30'h40});
    bus.calib_done = 1;
    wait_gnt(0);
    chk("cal_rd_gnt_low", 32'(bus.rd_gnt), 0);
    bus.wr_req = 0; bus.rd_req = 0; bus.calib_done = 0;
    repeat (2) tick();
    bus.wr_done = 1;
    tick();
    bus.wr_done = 0;
    drain("cal_seq_completes");
    bus.calib_done = 1;
    // reset while stalled in the write command state
    do_reset();
    c0 = cmd_cnt;
    bus.p0_cmd_full = 1; bus.wr_addr = 30'h1234; bus.wr_req = 1;
    wait_gnt(0);
    bus.wr_req = 0; bus.wr_done = 1;
    tick();
    bus.wr_done = 0;
    repeat (3) tick();
    chk("rc_addr_before", 32'(bus.p0_cmd_byte_addr), 32'h1234);
    reset = 1; bus.p0_cmd_full = 0;
    tick();
    chk("rc_wr_gnt", 32'(bus.wr_gnt), 0);
    chk("rc_rd_gnt", 32'(bus.rd_gnt), 0);
    chk("rc_cmd_en", 32'(bus.p0_cmd_en), 0);
    chk("rc_addr", 32'(bus.p0_cmd_byte_addr), 0);
    chk("rc_instr", 32'(bus.p0_cmd_instr), 0);
    reset = 0;
    repeat (5) tick();
    chk("rc_no_cmd", cmd_cnt - c0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr2_port_arbiter.md
DDR2_PORT_ARBITER -- requirements
Module: ddr2_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, meaning 32-bit words per command (range 2..64).
REQ-002 SHALL have parameter TIMEOUT, default 4095, meaning grant watchdog limit in clk cycles (12-bit counter).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port calib_done  input  1  memory calibration complete; no grants while low.
REQ-006 SHALL have port wr_req  input  1  write client requests the port.
REQ-007 SHALL have port wr_addr  input  30  write byte address, sampled at grant.
REQ-008 SHALL have port wr_gnt  output  1  write client owns the port.
REQ-009 SHALL have port wr_done  input  1  one-cycle pulse: BURST_LEN words loaded into the write FIFO.
REQ-010 SHALL have port rd_req  input  1  read client requests the port.
REQ-011 SHALL have port rd_addr  input  30  read byte address, sampled at grant.
REQ-012 SHALL have port rd_gnt  output  1  read client owns the port.
REQ-013 SHALL have port rd_done  input  1  one-cycle pulse: BURST_LEN words drained from the read FIFO.
REQ-014 SHALL have port p0_cmd_full  input  1  command FIFO full.
REQ-015 SHALL have port p0_cmd_en  output  1  command strobe.
REQ-016 SHALL have port p0_cmd_instr  output  3  3'b000 write, 3'b001 read.
REQ-017 SHALL have port p0_cmd_byte_addr  output  30  command byte address.
REQ-018 SHALL have port p0_cmd_bl  output  6  constant BURST_LEN-1.
REQ-019 SHALL have port timeout_err  output  1  sticky flag, set by watchdog expiry.

Function
REQ-020 SHALL implement states IDLE, WR_GNT, WR_CMD, RD_CMD, RD_GNT.
REQ-021 IDLE: with calib_done=1 and one request, SHALL grant that client; with both requests, SHALL grant the client not served last (round-robin; write wins the first tie after reset).
REQ-022 Grant SHALL register wr_addr/rd_addr into p0_cmd_byte_addr and assert wr_gnt/rd_gnt from the next cycle; at most one grant high at any time.
REQ-023 WR_GNT: SHALL hold wr_gnt until wr_done=1, then drop wr_gnt next cycle and go to WR_CMD.
REQ-024 WR_CMD: SHALL pulse p0_cmd_en for exactly one cycle with instr 3'b000 on the first cycle p0_cmd_full=0, then return to IDLE.
REQ-025 RD_CMD: SHALL pulse p0_cmd_en for exactly one cycle with instr 3'b001 on the first cycle p0_cmd_full=0, then go to RD_GNT; rd_gnt SHALL be high from grant through RD_GNT.
REQ-026 RD_GNT: SHALL drop rd_gnt the cycle after rd_done=1 and return to IDLE.
REQ-027 p0_cmd_byte_addr and p0_cmd_instr SHALL be stable while p0_cmd_en=1 and held until the next grant.
REQ-028 wr_done/rd_done outside the matching grant state SHALL be ignored.
REQ-029 A 12-bit watchdog SHALL clear on entry to WR_GNT/RD_GNT, increment each cycle there, and on reaching TIMEOUT SHALL drop the grant, set timeout_err, and return to IDLE without issuing a command.
REQ-030 Watchdog SHALL not run in WR_CMD/RD_CMD (waiting on p0_cmd_full is unbounded).
REQ-031 calib_done falling SHALL block new grants only; a sequence in progress SHALL complete.
REQ-032 Returning to IDLE SHALL allow a new grant on the following cycle (minimum one IDLE cycle between sequences).

Reset
REQ-033 While reset=1: state IDLE, wr_gnt=0, rd_gnt=0, p0_cmd_en=0, p0_cmd_instr=0, p0_cmd_byte_addr=0, timeout_err=0, round-robin pointer set so write wins next tie, watchdog=0.
REQ-034 Reset asserted mid-sequence SHALL abort it the next cycle with no p0_cmd_en pulse.

Verification
REQ-035 wr_req=1 with wr_addr=0x80, wr_done 10 cycles after wr_gnt -> exactly one p0_cmd_en, instr 000, addr 0x80, p0_cmd_bl=31.
REQ-036 wr_req and rd_req both held for 4 sequences -> grants alternate W,R,W,R; never both high.
REQ-037 rd_req with p0_cmd_full=1 for 20 cycles -> p0_cmd_en on the first cycle full=0, instr 001, rd_gnt stays high until rd_done.
REQ-038 Grant then no done, TIMEOUT=15 -> grant drops after 15 cycles, timeout_err=1 held, no p0_cmd_en pulse.
REQ-039 calib_done=0 with both requests -> no grants; calib_done rises -> write granted first.
REQ-040 reset pulsed in WR_CMD with p0_cmd_full=1 -> all outputs at reset values, no command issued.
